// File: rtl/nv_fifo_ctrl_128x18_pkg.sv
// Shared constants and types for the 128x18 FIFO controller slice.
package nv_fifo_ctrl_pkg;

  localparam int unsigned DEPTH      = 128;
  localparam int unsigned AW         = 7;
  localparam int unsigned DW         = 18;
  localparam int unsigned OBUF_DEPTH = 2;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned MAX_COUNT  = DEPTH + OBUF_DEPTH;

  typedef logic [DW-1:0]    data_t;
  typedef logic [AW-1:0]    addr_t;
  typedef logic [AW:0]      ram_cnt_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/nv_fifo_ctrl_128x18_if.sv
// Stream and RAM-port bundle between the FIFO controller and its surroundings.
interface nv_fifo_ctrl_128x18_if;
  import nv_fifo_ctrl_pkg::*;

  logic  wr_pvld;
  logic  wr_prdy;
  data_t wr_pd;
  logic  rd_pvld;
  logic  rd_prdy;
  data_t rd_pd;
  logic  ram_we;
  addr_t ram_wa;
  data_t ram_di;
  logic  ram_re;
  addr_t ram_ra;
  data_t ram_dout;
  cnt_t  fifo_count;

  // Environment side: producer, consumer and RAM read data.
  modport master (
    output wr_pvld, wr_pd, rd_prdy, ram_dout,
    input  wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di, ram_re, ram_ra, fifo_count
  );

  // Controller side.
  modport slave (
    input  wr_pvld, wr_pd, rd_prdy, ram_dout,
    output wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di, ram_re, ram_ra, fifo_count
  );

endinterface

// File: rtl/nv_fifo_ctrl_128x18_obuf.sv
// Two-entry in-order output buffer that absorbs the RAM's registered-read latency.
module nv_fifo_ctrl_obuf
  import nv_fifo_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cap,
  input  data_t      i_cap_data,
  input  logic       i_pop,
  output logic       o_vld,
  output data_t      o_data,
  output logic [1:0] o_cnt
);

  data_t      r_ent0;
  data_t      r_ent1;
  logic [1:0] r_cnt;
  data_t      w_ent0_d;
  data_t      w_ent1_d;
  logic [1:0] w_cnt_d;

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_comb begin
    w_ent0_d = r_ent0;
    w_ent1_d = r_ent1;
    w_cnt_d  = r_cnt;
    case ({i_cap, i_pop})
      2'b10: begin
        if (r_cnt == 2'd0) w_ent0_d = i_cap_data;
        else               w_ent1_d = i_cap_data;
        w_cnt_d = r_cnt + 2'd1;
      end
      2'b01: begin
        w_ent0_d = r_ent1;
        w_cnt_d  = r_cnt - 2'd1;
      end
      2'b11: begin
        if (r_cnt == 2'd2) begin
          w_ent0_d = r_ent1;
          w_ent1_d = i_cap_data;
        end else begin
          w_ent0_d = i_cap_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ent0 <= '0;
      r_ent1 <= '0;
      r_cnt  <= 2'd0;
    end else begin
      r_ent0 <= w_ent0_d;
      r_ent1 <= w_ent1_d;
      r_cnt  <= w_cnt_d;
    end
  end

  assign o_vld  = (r_cnt != 2'd0);
  assign o_data = r_ent0;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/nv_fifo_ctrl_128x18.sv
// Valid/ready FIFO controller for a 128x18 registered-read RAM with read prefetch.
module nv_fifo_ctrl_128x18
  import nv_fifo_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  nv_fifo_ctrl_128x18_if.slave  bus
);

  localparam ram_cnt_t RamFull = ram_cnt_t'(DEPTH);

  addr_t      r_wr_ptr;
  addr_t      r_rd_ptr;
  ram_cnt_t   r_ram_cnt;
  logic       r_inflight;
  logic       r_wr_prdy;
  ram_cnt_t   w_ram_cnt_d;
  logic       w_push;
  logic       w_pop;
  logic       w_issue;
  logic       w_rd_pvld;
  data_t      w_rd_pd;
  logic [1:0] w_obuf_cnt;
  logic [2:0] w_pending;

  assign w_push    = bus.wr_pvld & r_wr_prdy & ~rst;
  assign w_pop     = w_rd_pvld & bus.rd_prdy;
  // Words that will sit in the output buffer or be on their way there after this cycle.
  assign w_pending = 3'(w_obuf_cnt) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue   = ~rst & (r_ram_cnt != '0) & (w_pending < 3'd2);

  assign w_ram_cnt_d = r_ram_cnt + ram_cnt_t'(w_push) - ram_cnt_t'(w_issue);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_wr_prdy  <= 1'b0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + addr_t'(1);
      if (w_issue) r_rd_ptr <= r_rd_ptr + addr_t'(1);
      r_ram_cnt  <= w_ram_cnt_d;
      r_inflight <= w_issue;
      // Registered ready: a slot freed by this cycle's issue only opens next cycle.
      r_wr_prdy  <= (w_ram_cnt_d != RamFull);
    end
  end

  nv_fifo_ctrl_obuf u_obuf (
    .clk        (clk),
    .rst        (rst),
    .i_cap      (r_inflight),
    .i_cap_data (bus.ram_dout),
    .i_pop      (w_pop),
    .o_vld      (w_rd_pvld),
    .o_data     (w_rd_pd),
    .o_cnt      (w_obuf_cnt)
  );

  assign bus.wr_prdy    = r_wr_prdy;
  assign bus.rd_pvld    = w_rd_pvld;
  assign bus.rd_pd      = w_rd_pd;
  assign bus.ram_we     = w_push;
  assign bus.ram_wa     = r_wr_ptr;
  assign bus.ram_di     = bus.wr_pd;
  assign bus.ram_re     = w_issue;
  assign bus.ram_ra     = r_rd_ptr;
  assign bus.fifo_count = cnt_t'(r_ram_cnt) + cnt_t'(r_inflight) + cnt_t'(w_obuf_cnt);

endmodule

// File: tb/tb_nv_fifo_ctrl_128x18.sv
// Bench for nv_fifo_ctrl_128x18: vector table for reset/single word, scoreboard for streams.
module tb_nv_fifo_ctrl_128x18;
  import nv_fifo_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nv_fifo_ctrl_128x18_if ifc ();

  nv_fifo_ctrl_128x18 dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  // Behavioural 128x18 RAM with registered read; a same-edge write does not affect the read.
  logic [17:0] mem [128];
  always @(posedge clk) begin
    if (ifc.ram_re) ifc.ram_dout <= mem[ifc.ram_ra];
    if (ifc.ram_we) mem[ifc.ram_wa] <= ifc.ram_di;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and monitor state.
  logic [17:0] sb[$];
  logic        mon_en = 1'b0;
  logic        acc = 1'b0;
  logic        stalled = 1'b0;
  logic [17:0] stall_pd = '0;
  logic        no_bubble = 1'b0;
  logic        no_drop = 1'b0;
  logic [6:0]  exp_wa = '0;
  logic [6:0]  exp_ra = '0;
  int          wa_wraps = 0;
  int          ra_wraps = 0;
  int          npop = 0;

  always @(negedge clk) begin
    acc = 1'b0;
    if (mon_en) begin
      chk("fifo_count", 32'(ifc.fifo_count), 32'(sb.size()));
      if (ifc.ram_we) begin
        chk("ram_wa", 32'(ifc.ram_wa), 32'(exp_wa));
        if (exp_wa == 7'd127) wa_wraps++;
        exp_wa = exp_wa + 7'd1;
      end
      if (ifc.ram_re) begin
        chk("ram_ra", 32'(ifc.ram_ra), 32'(exp_ra));
        if (exp_ra == 7'd127) ra_wraps++;
        exp_ra = exp_ra + 7'd1;
      end
      if (stalled) begin
        chk("stall_pvld", 32'(ifc.rd_pvld), 32'd1);
        chk("stall_pd", 32'(ifc.rd_pd), 32'(stall_pd));
      end
      if (no_bubble) chk("no_bubble", 32'(ifc.rd_pvld), 32'd1);
      if (no_drop) chk("wr_prdy_hold", 32'(ifc.wr_prdy), 32'd1);
      if (ifc.rd_pvld && ifc.rd_prdy) begin
        npop++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_underflow: got %0h expected no pop at %0t", ifc.rd_pd, $time);
        end else begin
          chk("rd_pd", 32'(ifc.rd_pd), 32'(sb.pop_front()));
        end
      end
      stalled  = ifc.rd_pvld & ~ifc.rd_prdy;
      stall_pd = ifc.rd_pd;
      if (ifc.wr_pvld && ifc.wr_prdy) begin
        sb.push_back(ifc.wr_pd);
        acc = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    ifc.wr_pvld = 1'b0;
    ifc.rd_prdy = 1'b1;
    for (int c = 0; c < 400 && sb.size() != 0; c++) tick();
    tick();
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  typedef struct {
    logic        rst;
    logic        wv;
    logic [17:0] wd;
    logic        rr;
    logic        e_we;
    logic [6:0]  e_wa;
    logic        e_re;
    logic [6:0]  e_ra;
    logic        e_wrdy;
    logic        e_pvld;
    logic [17:0] e_pd;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt;
    int sent;
    int pops0;

    //           rst  wv    wd          rr    we    wa     re    ra     wrdy  pvld  pd          cnt
    vecs[0] = '{1'b1, 1'b1, 18'h00005, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 18'h00000, 8'd0};
    vecs[1] = '{1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 18'h00000, 8'd0};
    vecs[2] = '{1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b0, 18'h00000, 8'd0};
    vecs[3] = '{1'b0, 1'b1, 18'h2A5A5, 1'b1, 1'b1, 7'd0, 1'b0, 7'd0, 1'b1, 1'b0, 18'h00000, 8'd0};
    vecs[4] = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, 7'd1, 1'b1, 7'd0, 1'b1, 1'b0, 18'h00000, 8'd1};
    vecs[5] = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, 7'd1, 1'b0, 7'd1, 1'b1, 1'b0, 18'h00000, 8'd1};
    vecs[6] = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, 7'd1, 1'b0, 7'd1, 1'b1, 1'b1, 18'h2A5A5, 8'd1};
    vecs[7] = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, 7'd1, 1'b0, 7'd1, 1'b1, 1'b0, 18'h00000, 8'd0};

    ifc.wr_pvld = 1'b0;
    ifc.wr_pd   = '0;
    ifc.rd_prdy = 1'b0;
    repeat (2) @(posedge clk);

    // Reset values and single-word latency.
    for (int i = 0; i < 8; i++) begin
      #1;
      rst         = vecs[i].rst;
      ifc.wr_pvld = vecs[i].wv;
      ifc.wr_pd   = vecs[i].wd;
      ifc.rd_prdy = vecs[i].rr;
      @(negedge clk);
      chk($sformatf("v%0d_ram_we", i), 32'(ifc.ram_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_ram_wa", i), 32'(ifc.ram_wa), 32'(vecs[i].e_wa));
      chk($sformatf("v%0d_ram_re", i), 32'(ifc.ram_re), 32'(vecs[i].e_re));
      chk($sformatf("v%0d_ram_ra", i), 32'(ifc.ram_ra), 32'(vecs[i].e_ra));
      chk($sformatf("v%0d_wr_prdy", i), 32'(ifc.wr_prdy), 32'(vecs[i].e_wrdy));
      chk($sformatf("v%0d_rd_pvld", i), 32'(ifc.rd_pvld), 32'(vecs[i].e_pvld));
      chk($sformatf("v%0d_count", i), 32'(ifc.fifo_count), 32'(vecs[i].e_cnt));
      if (vecs[i].e_pvld) chk($sformatf("v%0d_rd_pd", i), 32'(ifc.rd_pd), 32'(vecs[i].e_pd));
      @(posedge clk);
    end
    #1;
    ifc.wr_pvld = 1'b0;
    ifc.rd_prdy = 1'b0;
    exp_wa = 7'd1;
    exp_ra = 7'd1;
    mon_en = 1'b1;

    // Fill with the consumer stalled: exactly MAX_COUNT words fit.
    nxt = 0;
    ifc.wr_pvld = 1'b1;
    ifc.wr_pd   = 18'(nxt);
    for (int c = 0; c < 260; c++) begin
      tick();
      if (acc) nxt++;
      ifc.wr_pd = 18'(nxt);
      if (nxt >= 200) ifc.wr_pvld = 1'b0;
    end
    @(negedge clk);
    chk("fill_accepted", 32'(nxt), 32'(MAX_COUNT));
    chk("fill_count", 32'(ifc.fifo_count), 32'(MAX_COUNT));
    chk("fill_wr_prdy", 32'(ifc.wr_prdy), 32'd0);
    tick();
    ifc.wr_pvld = 1'b0;
    ifc.rd_prdy = 1'b1;
    pops0 = npop;
    no_bubble = 1'b1;
    repeat (MAX_COUNT) tick();
    no_bubble = 1'b0;
    chk("fill_pops", 32'(npop - pops0), 32'(MAX_COUNT));
    drain("fill_drain");

    // Streaming at full rate in both directions.
    ifc.wr_pvld = 1'b1;
    ifc.rd_prdy = 1'b1;
    no_drop = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      ifc.wr_pd = 18'(k + 1000);
      if (k == 3) no_bubble = 1'b1;
      tick();
    end
    no_bubble = 1'b0;
    no_drop = 1'b0;
    drain("stream_drain");

    // Wrap-around of both RAM pointers.
    wa_wraps = 0;
    ra_wraps = 0;
    ifc.wr_pvld = 1'b1;
    ifc.rd_prdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      ifc.wr_pd = 18'h20000 | 18'(k);
      tick();
    end
    drain("wrap_drain");
    chk("wa_wrapped_twice", 32'(wa_wraps >= 2), 32'd1);
    chk("ra_wrapped_twice", 32'(ra_wraps >= 2), 32'd1);

    // Random backpressure on both sides.
    sent = 0;
    for (int c = 0; c < 30000 && sent < 5000; c++) begin
      ifc.wr_pvld = 1'($urandom_range(0, 1));
      ifc.wr_pd   = 18'($urandom);
      ifc.rd_prdy = 1'($urandom_range(0, 1));
      tick();
      if (acc) sent++;
    end
    ifc.wr_pvld = 1'b0;
    chk("bp_sent", 32'(sent), 32'd5000);
    drain("bp_drain");

    // Reset with 50 words held.
    ifc.rd_prdy = 1'b0;
    ifc.wr_pvld = 1'b1;
    sent = 0;
    for (int c = 0; c < 200 && sent < 50; c++) begin
      ifc.wr_pd = 18'h10000 | 18'(c);
      tick();
      if (acc) sent++;
    end
    ifc.wr_pvld = 1'b0;
    tick();
    chk("rst_pre_count", 32'(ifc.fifo_count), 32'd50);
    mon_en = 1'b0;
    rst = 1'b1;
    ifc.wr_pvld = 1'b1;
    ifc.wr_pd = 18'h3FFFF;
    ifc.rd_prdy = 1'b1;
    @(negedge clk);
    chk("rst_ram_we", 32'(ifc.ram_we), 32'd0);
    chk("rst_ram_re", 32'(ifc.ram_re), 32'd0);
    tick();
    rst = 1'b0;
    ifc.wr_pvld = 1'b0;
    ifc.rd_prdy = 1'b0;
    @(negedge clk);
    chk("post_rst_pvld", 32'(ifc.rd_pvld), 32'd0);
    chk("post_rst_count", 32'(ifc.fifo_count), 32'd0);
    sb.delete();
    exp_wa = '0;
    exp_ra = '0;
    stalled = 1'b0;
    tick();
    mon_en = 1'b1;
    for (int c = 0; c < 5 && !ifc.wr_prdy; c++) tick();
    chk("post_rst_wr_prdy", 32'(ifc.wr_prdy), 32'd1);
    pops0 = npop;
    ifc.wr_pvld = 1'b1;
    ifc.wr_pd = 18'h01234;
    ifc.rd_prdy = 1'b1;
    @(negedge clk);
    chk("post_rst_wa", 32'(ifc.ram_wa), 32'd0);
    tick();
    drain("post_rst_drain");
    chk("post_rst_pops", 32'(npop - pops0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
